au_controller: RTL

AU_CONTROLLER -- requirements
Module: au_controller

---
 rtl/au_controller_if.sv | 16 +
 rtl/au_controller.sv | 80 ++++++++
 2 files changed

// File: rtl/au_controller_if.sv
// au_controller_if: operation request and result handshake bundle for au_controller.
interface au_controller_if #(parameter int N = 8);
  logic         op_valid;
  logic         op_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_sub;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic [3:0]   res_cc;
  modport master (output op_valid, op_a, op_b, op_sub, res_ready,
                  input  op_ready, res_valid, res_data, res_cc);
  modport slave  (input  op_valid, op_a, op_b, op_sub, res_ready,
                  output op_ready, res_valid, res_data, res_cc);
endinterface

// File: rtl/au_controller.sv
// au_controller: sequences an external add/sub unit through load-A, load-B, execute and response.
// Optional sticky overflow flag enabled by AU_CTRL_OVF_STICKY_EN.
module au_controller #(parameter int N = 8) (
  input  logic         clk,
  input  logic         clear_n,
  au_controller_if.slave bus,
  output logic [N-1:0] au_the_input,
  output logic         au_inA,
  output logic         au_inB,
  output logic         au_out,
  output logic         au_add_sub_control,
  output logic         au_clear,
  input  logic [N-1:0] au_rout,
  input  logic [3:0]   au_ccout,
  output logic         ovf_sticky,
  input  logic         ovf_clr
);
  typedef enum logic [2:0] {INIT, IDLE, LOAD_A, LOAD_B, EXEC, RESP} state_t;
  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic         sub_q, sub_d;
  logic         accept;
  assign accept = (state_q == IDLE) && bus.op_valid;
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= INIT;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
    end
  end
  always_comb begin
    a_d   = accept ? bus.op_a   : a_q;
    b_d   = accept ? bus.op_b   : b_q;
    sub_d = accept ? bus.op_sub : sub_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = IDLE;
      IDLE:    state_d = bus.op_valid ? LOAD_A : IDLE;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = bus.res_ready ? IDLE : RESP;
      default: state_d = INIT;
    endcase
  end
  // Moore outputs; result passes straight from the AU registers, which only load in EXEC
  always_comb begin
    bus.op_ready       = state_q == IDLE;
    bus.res_valid      = state_q == RESP;
    bus.res_data       = (state_q == RESP) ? au_rout  : '0;
    bus.res_cc         = (state_q == RESP) ? au_ccout : 4'b0;
    au_clear           = state_q == INIT;
    au_inA             = state_q == LOAD_A;
    au_inB             = state_q == LOAD_B;
    au_out             = state_q == EXEC;
    au_add_sub_control = sub_q;
    au_the_input       = (state_q == LOAD_A) ? a_q : (state_q == LOAD_B) ? b_q : '0;
  end
`ifdef AU_CTRL_OVF_STICKY_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = (bus.res_valid && bus.res_ready && au_ccout[1]) || (ovf_q && !ovf_clr);
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end
  assign ovf_sticky = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif
endmodule
